// File: rtl/gcd_binary_unit.sv
// Binary (Stein) GCD engine: shift/subtract only, with zero-operand handling,
// error flag, busy flag and a saturating per-operation cycle counter.
module gcd_binary_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] cycles
);

  localparam int K_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STRIP  = 3'd1;
  localparam logic [2:0] S_REDUCE = 3'd2;
  localparam logic [2:0] S_FIX    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [K_W-1:0]   r_k;
  logic [WIDTH-1:0] r_out;
  logic             r_err;
  logic [CNT_W-1:0] r_cycles;

  logic [2:0]       w_state_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [K_W-1:0]   w_k_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_err_nxt;
  logic [CNT_W-1:0] w_cycles_nxt;

  logic [CNT_W-1:0] w_cycles_inc;
  logic             w_x_zero;
  logic             w_y_zero;

  // Counter sticks at all-ones instead of wrapping.
  assign w_cycles_inc = (r_cycles == {CNT_W{1'b1}}) ? r_cycles : r_cycles + 1'b1;
  assign w_x_zero     = (x == '0);
  assign w_y_zero     = (y == '0);

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_k_nxt      = r_k;
    w_out_nxt    = r_out;
    w_err_nxt    = r_err;
    w_cycles_nxt = r_cycles;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt      = x;
          w_b_nxt      = y;
          w_k_nxt      = '0;
          w_cycles_nxt = '0;
          w_err_nxt    = 1'b0;
          if (w_x_zero || w_y_zero) begin
            w_out_nxt   = x | y;
            w_err_nxt   = w_x_zero && w_y_zero;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_STRIP;
          end
        end
      end

      S_STRIP: begin
        w_cycles_nxt = w_cycles_inc;
        // Pull out the common power of two; it is restored in FIX.
        if (!r_a[0] && !r_b[0]) begin
          w_a_nxt = r_a >> 1;
          w_b_nxt = r_b >> 1;
          w_k_nxt = r_k + 1'b1;
        end else begin
          w_state_nxt = S_REDUCE;
        end
      end

      S_REDUCE: begin
        w_cycles_nxt = w_cycles_inc;
        if (!r_a[0]) begin
          w_a_nxt = r_a >> 1;
        end else if (!r_b[0]) begin
          w_b_nxt = r_b >> 1;
        end else if (r_a == r_b) begin
          w_state_nxt = S_FIX;
        end else if (r_a > r_b) begin
          w_a_nxt = r_a - r_b;
        end else begin
          w_b_nxt = r_b - r_a;
        end
      end

      S_FIX: begin
        w_cycles_nxt = w_cycles_inc;
        w_out_nxt    = r_a << r_k;
        w_state_nxt  = S_DONE;
      end

      S_DONE: begin
        if (!start) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_out    <= '0;
      r_err    <= 1'b0;
      r_cycles <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_k      <= w_k_nxt;
      r_out    <= w_out_nxt;
      r_err    <= w_err_nxt;
      r_cycles <= w_cycles_nxt;
    end
  end

  assign out    = r_out;
  assign err    = r_err;
  assign cycles = r_cycles;
  assign done   = (r_state == S_DONE);
  assign busy   = (r_state == S_STRIP) || (r_state == S_REDUCE) || (r_state == S_FIX);

endmodule
